// File: rtl/fetch_if.sv
// Fetch-stage bus between the fetch controller and the rest of the pipeline.
// The master side is the controller; the slave side is the hazard/ID/EX/ROM environment.
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        irq;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        flush_id;
  logic [31:0] epc;
  logic        irq_ack;
  logic [31:0] fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, irq, instr_in,
    output pc, if_id_instr, if_id_pc4, if_id_valid, flush_id, epc, irq_ack, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, irq, instr_in,
    input  pc, if_id_instr, if_id_pc4, if_id_valid, flush_id, epc, irq_ack, fetch_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills IF/ID and picks next-PC among
// taken branch, stall, jump, interrupt entry and sequential fetch.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004
) (
  input  logic clk,
  input  logic reset,
  fetch_if.master bus
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state_r, state_n;
  logic [31:0] pc_r, pc_n;
  logic [31:0] instr_r, instr_n;
  logic [31:0] pc4_r, pc4_n;
  logic        valid_r, valid_n;
  logic [31:0] epc_r, epc_n;
  logic [31:0] cnt_r, cnt_n;

  logic        run_s;
  logic        jump_ok_s;
  logic        irq_ok_s;
  logic        irq_take_s;
  logic [31:0] pc_plus4_s;

  // A jump is only honoured when ID really holds the instruction that produced it.
  assign run_s      = (state_r == RUN);
  assign jump_ok_s  = bus.jump && valid_r;
  assign irq_ok_s   = bus.irq && !pc_r[31];
  assign irq_take_s = run_s && !bus.branch_taken && !bus.stall && !jump_ok_s && irq_ok_s;
  assign pc_plus4_s = pc_r + 32'd4;

  assign bus.pc          = pc_r;
  assign bus.if_id_instr = instr_r;
  assign bus.if_id_pc4   = pc4_r;
  assign bus.if_id_valid = valid_r;
  assign bus.epc         = epc_r;
  assign bus.fetch_count = cnt_r;
  assign bus.flush_id    = run_s && bus.branch_taken;
  assign bus.irq_ack     = irq_take_s;

  // Next-state selection in priority order: branch, stall, jump, interrupt, sequential.
  always_comb begin
    state_n = state_r;
    pc_n    = pc_r;
    instr_n = instr_r;
    pc4_n   = pc4_r;
    valid_n = valid_r;
    epc_n   = epc_r;
    cnt_n   = cnt_r;
    case (state_r)
      BOOT: begin
        state_n = RUN;
      end
      RUN: begin
        if (bus.branch_taken) begin
          pc_n    = {bus.branch_target[31:2], 2'b00};
          instr_n = 32'd0;
          valid_n = 1'b0;
        end else if (bus.stall) begin
          pc_n = pc_r;
        end else if (jump_ok_s) begin
          pc_n    = {bus.jump_target[31:2], 2'b00};
          instr_n = 32'd0;
          valid_n = 1'b0;
        end else if (irq_ok_s) begin
          epc_n   = pc_r;
          pc_n    = {IRQ_VECTOR[31:2], 2'b00};
          instr_n = 32'd0;
          valid_n = 1'b0;
        end else begin
          pc_n    = pc_plus4_s;
          instr_n = bus.instr_in;
          pc4_n   = pc_plus4_s;
          valid_n = 1'b1;
          cnt_n   = cnt_r + 32'd1;
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  // PC, IF/ID, EPC and fetch counter registers; reset discards any pending redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= BOOT;
      pc_r    <= {RESET_PC[31:2], 2'b00};
      instr_r <= 32'd0;
      pc4_r   <= 32'd0;
      valid_r <= 1'b0;
      epc_r   <= 32'd0;
      cnt_r   <= 32'd0;
    end else begin
      state_r <= state_n;
      pc_r    <= pc_n;
      instr_r <= instr_n;
      pc4_r   <= pc4_n;
      valid_r <= valid_n;
      epc_r   <= epc_n;
      cnt_r   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: fixed vector table, directed corner sequences,
// and random stimulus against a rule-level reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_ctrl #(.RESET_PC(RESET_PC), .IRQ_VECTOR(IRQ_VECTOR)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h2408_0000 + (a - RESET_PC);
  endfunction

  assign bus.instr_in = rom(bus.pc);

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_run;
  logic [31:0] m_pc, m_instr, m_pc4, m_epc, m_cnt;
  logic        m_valid;
  logic        exp_ack, exp_flush, got_ack, got_flush;

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        iq;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
    logic        e_flush;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_pc    = RESET_PC;
    m_instr = 32'd0;
    m_pc4   = 32'd0;
    m_epc   = 32'd0;
    m_cnt   = 32'd0;
    m_valid = 1'b0;
  endtask

  // One clock: drive on the falling edge, sample combinational outputs, update model at the rising edge.
  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic iq);
    @(negedge clk);
    bus.stall = st;
    bus.branch_taken = br;
    bus.branch_target = bt;
    bus.jump = j;
    bus.jump_target = jt;
    bus.irq = iq;
    #1;
    got_ack   = bus.irq_ack;
    got_flush = bus.flush_id;
    exp_flush = m_run && br;
    exp_ack   = m_run && !br && !st && !(j && m_valid) && iq && !m_pc[31];
    @(posedge clk);
    if (!m_run) begin
      m_run = 1'b1;
    end else if (br) begin
      m_pc = bt & 32'hFFFF_FFFC; m_instr = 32'd0; m_valid = 1'b0;
    end else if (st) begin
      m_run = 1'b1;
    end else if (j && m_valid) begin
      m_pc = jt & 32'hFFFF_FFFC; m_instr = 32'd0; m_valid = 1'b0;
    end else if (iq && !m_pc[31]) begin
      m_epc = m_pc; m_pc = IRQ_VECTOR; m_instr = 32'd0; m_valid = 1'b0;
    end else begin
      m_instr = rom(m_pc); m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic seq();
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"}, bus.pc, m_pc);
    chk({tag, ".instr"}, bus.if_id_instr, m_instr);
    chk({tag, ".pc4"}, bus.if_id_pc4, m_pc4);
    chk({tag, ".valid"}, {31'd0, bus.if_id_valid}, {31'd0, m_valid});
    chk({tag, ".epc"}, bus.epc, m_epc);
    chk({tag, ".count"}, bus.fetch_count, m_cnt);
    chk({tag, ".ack"}, {31'd0, got_ack}, {31'd0, exp_ack});
    chk({tag, ".flush"}, {31'd0, got_flush}, {31'd0, exp_flush});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".pc"}, bus.pc, RESET_PC);
    chk({tag, ".instr"}, bus.if_id_instr, 32'd0);
    chk({tag, ".pc4"}, bus.if_id_pc4, 32'd0);
    chk({tag, ".valid"}, {31'd0, bus.if_id_valid}, 32'd0);
    chk({tag, ".epc"}, bus.epc, 32'd0);
    chk({tag, ".count"}, bus.fetch_count, 32'd0);
    chk({tag, ".ack"}, {31'd0, bus.irq_ack}, 32'd0);
  endtask

  initial begin
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
    bus.jump = 1'b0; bus.jump_target = 32'd0; bus.irq = 1'b0;
    model_reset();

    // row: st br bt j jt iq | pc instr pc4 valid count flush
    tbl[0] = '{1'b0, 1'b1, 32'h0040_0500, 1'b0, 32'h0, 1'b0, 32'h0040_0000, 32'h0,         32'h0,         1'b0, 32'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0040_0004, 32'h2408_0000, 32'h0040_0004, 1'b1, 32'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0040_0008, 32'h2408_0004, 32'h0040_0008, 1'b1, 32'd2, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0024, 1'b0, 32'h0040_0024, 32'h0,     32'h0040_0008, 1'b0, 32'd2, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0040_0090, 1'b0, 32'h0040_0028, 32'h2408_0024, 32'h0040_0028, 1'b1, 32'd3, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 32'h0040_0143, 1'b0, 32'h0, 1'b0, 32'h0040_0140, 32'h0,         32'h0040_0028, 1'b0, 32'd3, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0040_0140, 32'h0,         32'h0040_0028, 1'b0, 32'd3, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0040_0144, 32'h2408_0140, 32'h0040_0144, 1'b1, 32'd4, 1'b0};

    #12;
    check_reset_values("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].st, tbl[i].br, tbl[i].bt, tbl[i].j, tbl[i].jt, tbl[i].iq);
      chk($sformatf("vec%0d.pc", i), bus.pc, tbl[i].e_pc);
      chk($sformatf("vec%0d.instr", i), bus.if_id_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d.pc4", i), bus.if_id_pc4, tbl[i].e_pc4);
      chk($sformatf("vec%0d.valid", i), {31'd0, bus.if_id_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d.count", i), bus.fetch_count, tbl[i].e_cnt);
      chk($sformatf("vec%0d.flush", i), {31'd0, got_flush}, {31'd0, tbl[i].e_flush});
    end

    // stall held three cycles at 0x00400030, then release
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0030, 1'b0);
    chk("stall.setup", bus.pc, 32'h0040_0030);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b1, 32'h0040_0800, 1'b1);
      chk("stall.pc", bus.pc, 32'h0040_0030);
      check_model("stall");
    end
    seq();
    chk("stall.release", bus.pc, 32'h0040_0034);
    check_model("release");

    // interrupt entry, no re-entry in kernel, re-entry after jump back to user
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0100, 1'b0);
    chk("irq.setup", bus.pc, 32'h0040_0100);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("irq.ack", {31'd0, got_ack}, 32'd1);
    chk("irq.epc", bus.epc, 32'h0040_0100);
    chk("irq.vector", bus.pc, 32'h8000_0004);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("irq.kernel_ack", {31'd0, got_ack}, 32'd0);
    chk("irq.kernel_pc", bus.pc, 32'h8000_0008);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0040_0100, 1'b1);
    chk("irq.ret_ack", {31'd0, got_ack}, 32'd0);
    chk("irq.ret_pc", bus.pc, 32'h0040_0100);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("irq.reenter_ack", {31'd0, got_ack}, 32'd1);
    chk("irq.reenter_pc", bus.pc, 32'h8000_0004);
    check_model("irq");

    // pc+4 wraps through 2^32
    seq();
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    chk("wrap.setup", bus.pc, 32'hFFFF_FFFC);
    seq();
    chk("wrap.pc", bus.pc, 32'h0000_0000);
    check_model("wrap");

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt, jt;
      bt = {1'b0, 7'd0, 4'h4, $urandom_range(0, 20'hFFFFF)};
      jt = {($urandom_range(0, 3) == 0), 7'd0, 4'h4, $urandom_range(0, 20'hFFFFF)};
      step($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, bt,
           $urandom_range(0, 5) == 0, jt, $urandom_range(0, 3) == 0);
      check_model("rand");
    end

    // asynchronous reset mid-cycle
    while (m_cnt < 32'd50) seq();
    @(negedge clk);
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0; bus.irq = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b0, 1'b1, 32'h0040_0700, 1'b0, 32'd0, 1'b0);
    chk("boot.pc", bus.pc, RESET_PC);
    chk("boot.flush", {31'd0, got_flush}, 32'd0);
    chk("boot.valid", {31'd0, bus.if_id_valid}, 32'd0);
    seq();
    chk("first.instr", bus.if_id_instr, 32'h2408_0000);
    chk("first.count", bus.fetch_count, 32'd1);
    check_model("first");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the five-stage MIPS pipeline. Owns the program counter and drives the instruction ROM address. Captures the returned word into the IF/ID register. Resolves next-PC among sequential, jump/jr (ID), taken branch (EX), external interrupt and hazard stall.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, fetch address after reset.
- IRQ_VECTOR, 32'h8000_0004, interrupt handler entry; bit 31 set marks kernel mode.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  load-use hazard from hazard unit; hold PC and IF/ID.
- branch_taken  in  1  taken branch resolved in EX.
- branch_target  in  32  EX branch destination.
- jump  in  1  j/jal decoded in ID.
- jump_target  in  32  ID jump destination.
- irq  in  1  level-sensitive external interrupt.
- instr_in  in  32  word returned by instruction ROM for current pc.
- pc  out  32  ROM address, registered.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc4  out  32  IF/ID pc+4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- flush_id  out  1  combinational; kill ID→EX this cycle.
- epc  out  32  return address saved on interrupt entry.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- fetch_count  out  32  number of instructions loaded into IF/ID.

## Operation
- FSM: BOOT → RUN. reset forces BOOT. BOOT lasts exactly one cycle after reset deasserts and performs no IF/ID capture. RUN then persists until reset.
- Kernel mode: pc[31]==1. Leaving kernel happens only by a jump target with bit 31 clear. jr targets arrive on jump/jump_target.
- Next-PC priority in RUN, highest first:
  1. branch_taken: pc←branch_target; IF/ID←bubble; flush_id=1. Overrides stall.
  2. stall: pc, IF/ID, epc and fetch_count hold. jump and irq are ignored this cycle.
  3. jump (only if if_id_valid): pc←jump_target; IF/ID←bubble. There is no delay slot.
  4. irq && !pc[31] && !branch/jump: epc←pc; pc←IRQ_VECTOR; IF/ID←bubble; irq_ack=1.
  5. Otherwise: pc←pc+4; IF/ID←{instr_in, pc+4, valid=1}; fetch_count+1.
- Bubble: if_id_instr=0 (sll nop), if_id_pc4 holds, if_id_valid=0.
- pc+4 wraps modulo 2^32. pc[1:0] always 0; targets are used as given, with bits 1:0 forced to 0.
- fetch_count wraps at 2^32−1 → 0. It never increments on a bubble, stall or BOOT.
- irq held high while in kernel does not re-enter. After return to user mode, a still-high irq is taken on the next eligible cycle.

## Timing
- Reset values: pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, epc=0, irq_ack=0, fetch_count=0, state=BOOT.
- ROM is combinational. The instruction at pc is in IF/ID at the clk edge that advances pc.
- First valid IF/ID: second rising edge after reset deasserts, holding the word at RESET_PC.
- Redirect penalty: jump costs 1 bubble and taken branch costs 2 bubbles. The IF/ID kill is local; the ID kill is signalled via flush_id.
- flush_id depends only on branch_taken and state==RUN. It is 0 in BOOT.
- irq_ack is high for exactly the cycle whose edge loads IRQ_VECTOR.
- Reset mid-operation: all state returns to reset values immediately, asynchronously. Pending redirects are lost.

## Test plan
- Reset release with no hazards → pc sequence 0x00400000, 0x00400004, 0x00400008. First if_id_valid=1 on the 2nd edge with instr_in=0x24080000. fetch_count=1 after that edge.
- jump with jump_target=0x00400024 while pc=0x0040003C → next pc=0x00400024. One IF/ID bubble (valid=0, instr=0). fetch_count does not count the bubble.
- branch_taken and stall in the same cycle, branch_target=0x00400140 → pc=0x00400140; flush_id=1; IF/ID bubble; stall ignored.
- stall held 3 cycles at pc=0x00400030 → pc, if_id_* and fetch_count constant. Release → pc=0x00400034.
- irq at pc=0x00400100 → epc=0x00400100; pc=0x80000004; irq_ack one pulse. irq kept high → no re-entry. jump to 0x00400100 → irq taken again on the next sequential cycle.
- Assert reset while pc=0x00400200 and fetch_count=50 → immediately pc=0x00400000, fetch_count=0, if_id_valid=0, state BOOT.
